// File: rtl/video_ddr_pkg.sv
// Word format shared by the DDR write packer and the read-side unpacker.
package video_ddr_pkg;
    localparam int unsigned DEF_AXI4_DATA_WIDTH = 128;
    localparam int unsigned PIX_W               = 24;
    localparam int unsigned SLOT_W              = 32;
    localparam logic [7:0]  PAD_BYTE            = 8'hff;

    function automatic int unsigned pix_per_word(input int unsigned data_width);
        return data_width / SLOT_W;
    endfunction

    // LSB of pixel slot k; slot 0 sits at the MSB end, just below its pad byte.
    function automatic int unsigned pix_lsb(input int unsigned data_width, input int unsigned k);
        return data_width - SLOT_W * (k + 1);
    endfunction
endpackage

// File: rtl/video_edge_det.sv
// Single-polarity edge detector; RISING selects rising (1) or falling (0) edges.
module video_edge_det #(
    parameter bit RISING = 1'b1
) (
    input  logic video_clk,
    input  logic video_rst_n,
    input  logic sig,
    output logic edge_c
);
    logic sig_q;

    always_ff @(posedge video_clk or negedge video_rst_n) begin
        if (!video_rst_n) sig_q <= 1'b0;
        else              sig_q <= sig;
    end

    assign edge_c = RISING ? (sig & ~sig_q) : (~sig & sig_q);
endmodule

// File: rtl/video_from_fifo_ctrl.sv
// Unpacks DDR read-FIFO words into 24-bit pixels aligned to display timing.
// Optional VIDEO_FIFO_UNDERFLOW_CNT_EN adds a saturating per-frame underflow word counter.
module video_from_fifo_ctrl
    import video_ddr_pkg::*;
#(
    parameter int unsigned AXI4_DATA_WIDTH = DEF_AXI4_DATA_WIDTH,
    parameter logic [23:0] UNDERFLOW_RGB   = 24'h000000
) (
    input  logic                       video_clk,
    input  logic                       video_rst_n,
    input  logic                       video_vs_in,
    input  logic                       video_hs_in,
    input  logic                       video_de_in,
    input  logic [AXI4_DATA_WIDTH-1:0] fifo_data_in,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    output logic                       video_vs_out,
    output logic                       video_hs_out,
    output logic                       video_de_out,
    output logic [23:0]                video_data_out,
    output logic                       line_req_valid,
    input  logic                       line_req_ready,
    output logic                       frame_start,
    output logic                       underflow_flag
`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                underflow_cnt
`endif
);
    localparam int unsigned PPW   = pix_per_word(AXI4_DATA_WIDTH);
    localparam int unsigned CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PPW - 1);

    logic vs_rise_c, hs_fall_c, de_fall_c;
    logic word_start_c, underflow_c;

    logic [CNT_W-1:0]       pix_cnt, slot_d;
    logic                   pop_d, word_valid;
    logic                   vs_d1, hs_d1, de_d1;
    logic [PPW*PIX_W-1:0]   word_pix_c, word_reg, pix_src_c;
    logic [PPW*8-1:0]       unused_pad;
    logic [PIX_W-1:0]       pix_sel_c;

    video_edge_det #(.RISING(1'b1)) u_vs_edge (
        .video_clk(video_clk), .video_rst_n(video_rst_n), .sig(video_vs_in), .edge_c(vs_rise_c));
    video_edge_det #(.RISING(1'b0)) u_hs_edge (
        .video_clk(video_clk), .video_rst_n(video_rst_n), .sig(video_hs_in), .edge_c(hs_fall_c));
    video_edge_det #(.RISING(1'b0)) u_de_edge (
        .video_clk(video_clk), .video_rst_n(video_rst_n), .sig(video_de_in), .edge_c(de_fall_c));

    assign word_start_c = video_de_in & (pix_cnt == '0);
    assign underflow_c  = word_start_c & fifo_empty;
    // Gated by reset so a word is never lost while the block is held in reset.
    assign fifo_rd_en   = video_rst_n & word_start_c & ~fifo_empty;

    // Strip pad bytes; pixel 0 ends up at the MSB end of word_pix_c.
    for (genvar k = 0; k < PPW; k++) begin : g_unpack
        assign word_pix_c[(PPW-1-k)*PIX_W +: PIX_W] = fifo_data_in[pix_lsb(AXI4_DATA_WIDTH, k) +: PIX_W];
        assign unused_pad[k*8 +: 8] = fifo_data_in[pix_lsb(AXI4_DATA_WIDTH, k) + PIX_W +: 8];
    end

    // Slot 0 is taken straight from the FIFO the cycle its data lands.
    assign pix_src_c = (slot_d == '0) ? word_pix_c : word_reg;

    always_comb begin
        pix_sel_c = '0;
        for (int unsigned k = 0; k < PPW; k++) begin
            if (slot_d == CNT_W'(k)) pix_sel_c = pix_src_c[(PPW-1-k)*PIX_W +: PIX_W];
        end
    end

    // Stage 1: slot tracking, word capture and timing delay.
    always_ff @(posedge video_clk or negedge video_rst_n) begin
        if (!video_rst_n) begin
            pix_cnt    <= '0;
            slot_d     <= '0;
            pop_d      <= 1'b0;
            word_valid <= 1'b0;
            word_reg   <= '0;
            vs_d1      <= 1'b0;
            hs_d1      <= 1'b0;
            de_d1      <= 1'b0;
        end else begin
            vs_d1  <= video_vs_in;
            hs_d1  <= video_hs_in;
            de_d1  <= video_de_in;
            pop_d  <= fifo_rd_en;
            slot_d <= pix_cnt;
            if (video_de_in)    pix_cnt <= (pix_cnt == CNT_MAX) ? '0 : pix_cnt + CNT_W'(1);
            else if (de_fall_c) pix_cnt <= '0;
            if (word_start_c)   word_valid <= ~fifo_empty;
            if (pop_d)          word_reg <= word_pix_c;
        end
    end

    // Stage 2: registered outputs and line/frame control.
    always_ff @(posedge video_clk or negedge video_rst_n) begin
        if (!video_rst_n) begin
            video_vs_out   <= 1'b0;
            video_hs_out   <= 1'b0;
            video_de_out   <= 1'b0;
            video_data_out <= '0;
            frame_start    <= 1'b0;
            underflow_flag <= 1'b0;
            line_req_valid <= 1'b0;
        end else begin
            video_vs_out   <= vs_d1;
            video_hs_out   <= hs_d1;
            video_de_out   <= de_d1;
            video_data_out <= !de_d1 ? '0 : (word_valid ? pix_sel_c : UNDERFLOW_RGB);
            frame_start    <= vs_rise_c;
            if (vs_rise_c)        underflow_flag <= 1'b0;
            else if (underflow_c) underflow_flag <= 1'b1;
            if (vs_rise_c)                             line_req_valid <= 1'b0;
            else if (line_req_valid && line_req_ready) line_req_valid <= 1'b0;
            else if (hs_fall_c && !video_vs_in)        line_req_valid <= 1'b1;
        end
    end

`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
    always_ff @(posedge video_clk or negedge video_rst_n) begin
        if (!video_rst_n)                              underflow_cnt <= '0;
        else if (vs_rise_c)                            underflow_cnt <= '0;
        else if (underflow_c && underflow_cnt != '1)   underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_video_from_fifo_ctrl.sv
// Bench for video_from_fifo_ctrl: line-request vector table plus pixel scoreboard sequences.
module tb_video_from_fifo_ctrl;
    localparam int unsigned W      = 128;
    localparam logic [23:0] UF_RGB = 24'h3c81e7;

    logic           video_clk = 1'b0;
    logic           video_rst_n = 1'b0;
    logic           video_vs_in = 1'b0, video_hs_in = 1'b1, video_de_in = 1'b0;
    logic [W-1:0]   fifo_data_in = '0;
    logic           fifo_empty = 1'b1;
    logic           fifo_rd_en;
    logic           video_vs_out, video_hs_out, video_de_out;
    logic [23:0]    video_data_out;
    logic           line_req_valid;
    logic           line_req_ready = 1'b0;
    logic           frame_start;
    logic           underflow_flag;
`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
    logic [15:0]    underflow_cnt;
`endif

    always #5 video_clk = ~video_clk;

    video_from_fifo_ctrl #(.AXI4_DATA_WIDTH(W), .UNDERFLOW_RGB(UF_RGB)) dut (
        .video_clk(video_clk), .video_rst_n(video_rst_n),
        .video_vs_in(video_vs_in), .video_hs_in(video_hs_in), .video_de_in(video_de_in),
        .fifo_data_in(fifo_data_in), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .video_vs_out(video_vs_out), .video_hs_out(video_hs_out), .video_de_out(video_de_out),
        .video_data_out(video_data_out),
        .line_req_valid(line_req_valid), .line_req_ready(line_req_ready),
        .frame_start(frame_start), .underflow_flag(underflow_flag)
`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
        , .underflow_cnt(underflow_cnt)
`endif
    );

    // Standard (non-FWFT) FIFO model: data appears the cycle after the pop.
    logic [W-1:0] fifo_q[$];
    int           pops = 0;
    bit           force_empty = 1'b0;
    always @(posedge video_clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() > 0) fifo_data_in <= fifo_q.pop_front();
            pops <= pops + 1;
        end
    end

    // Expected output timing: inputs from two cycles earlier, zero through reset.
    logic [2:0] tm1, tm2;
    always @(posedge video_clk or negedge video_rst_n) begin
        if (!video_rst_n) begin
            tm1 <= '0;
            tm2 <= '0;
        end else begin
            tm1 <= {video_vs_in, video_hs_in, video_de_in};
            tm2 <= tm1;
        end
    end

    logic [23:0] exp_pix_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic vs, hs, rdy, exp_lrv, exp_fs;
    } lr_vec_t;
    lr_vec_t tbl[22];

    function automatic logic [W-1:0] mkword(input logic [23:0] p0, input logic [23:0] p1,
                                            input logic [23:0] p2, input logic [23:0] p3);
        return {8'hff, p0, 8'hff, p1, 8'hff, p2, 8'hff, p3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare timing and pop/compare the pixel scoreboard while outputs are stable.
    task automatic monitor();
        if (video_rst_n) begin
            chk("timing_vs_hs_de", 32'({video_vs_out, video_hs_out, video_de_out}), 32'(tm2));
            if (video_de_out) begin
                if (exp_pix_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pixel_unexpected: got %0h expected none at %0t", video_data_out, $time);
                end else begin
                    chk("pixel", 32'(video_data_out), 32'(exp_pix_q.pop_front()));
                end
            end
        end
    endtask

    task automatic cyc(input logic vs, input logic hs, input logic de);
        video_vs_in = vs;
        video_hs_in = hs;
        video_de_in = de;
        fifo_empty  = force_empty || (fifo_q.size() == 0);
        @(negedge video_clk);
        monitor();
        @(posedge video_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic line_px(input logic [23:0] px);
        exp_pix_q.push_back(px);
        cyc(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int pops0;
        logic [23:0] pa [8];
        logic [23:0] pd [8];

        pa = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD,
               24'hEEEEEE, 24'hFFFFFF, 24'h111111, 24'h222222};
        pd = '{24'h0a0a0a, 24'h0b0b0b, 24'h0c0c0c, 24'h0d0d0d,
               24'h515151, 24'h525252, 24'h535353, 24'h545454};

        //                vs    hs    rdy   lrv   fs
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with active-looking inputs and a non-empty FIFO.
        fifo_q.push_back(mkword(pa[0], pa[1], pa[2], pa[3]));
        fifo_q.push_back(mkword(pa[4], pa[5], pa[6], pa[7]));
        video_de_in = 1'b1;
        fifo_empty  = 1'b0;
        repeat (3) @(posedge video_clk);
        #1;
        chk("rst_vs_out", 32'(video_vs_out), 32'd0);
        chk("rst_hs_out", 32'(video_hs_out), 32'd0);
        chk("rst_de_out", 32'(video_de_out), 32'd0);
        chk("rst_data", 32'(video_data_out), 32'd0);
        chk("rst_line_req_valid", 32'(line_req_valid), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_underflow_flag", 32'(underflow_flag), 32'd0);
        chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
        chk("rst_underflow_cnt", 32'(underflow_cnt), 32'd0);
`endif
        video_de_in = 1'b0;
        @(posedge video_clk);
        #1;
        video_rst_n = 1'b1;
        idle(3);

        // Line request / frame start vectors.
        for (int i = 0; i < 22; i++) begin
            line_req_ready = tbl[i].rdy;
            cyc(tbl[i].vs, tbl[i].hs, 1'b0);
            chk($sformatf("line_req_valid[%0d]", i), 32'(line_req_valid), 32'(tbl[i].exp_lrv));
            chk($sformatf("frame_start[%0d]", i), 32'(frame_start), 32'(tbl[i].exp_fs));
        end
        line_req_ready = 1'b0;
        idle(2);
        chk("no_pop_outside_de", 32'(pops), 32'd0);

        // Two full words unpacked in order.
        pops0 = pops;
        for (int i = 0; i < 8; i++) line_px(pa[i]);
        idle(4);
        chk("lineA_pops", 32'(pops - pops0), 32'd2);
        chk("lineA_underflow_flag", 32'(underflow_flag), 32'd0);
        chk("lineA_scoreboard_drained", 32'(exp_pix_q.size()), 32'd0);

        // FIFO empty for the whole line.
        force_empty = 1'b1;
        pops0 = pops;
        for (int i = 0; i < 8; i++) line_px(UF_RGB);
        idle(4);
        chk("lineB_pops", 32'(pops - pops0), 32'd0);
        chk("lineB_underflow_flag", 32'(underflow_flag), 32'd1);
`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
        chk("lineB_underflow_cnt", 32'(underflow_cnt), 32'd2);
`endif
        cyc(1'b1, 1'b1, 1'b0);
        chk("vs_frame_start", 32'(frame_start), 32'd1);
        chk("vs_clears_flag", 32'(underflow_flag), 32'd0);
`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
        chk("vs_clears_cnt", 32'(underflow_cnt), 32'd0);
`endif
        cyc(1'b0, 1'b1, 1'b0);
        chk("frame_start_one_cycle", 32'(frame_start), 32'd0);
        force_empty = 1'b0;
        idle(2);

        // One word available, then underflow on the second word.
        fifo_q.push_back(mkword(24'h123456, 24'h234567, 24'h345678, 24'h456789));
        pops0 = pops;
        line_px(24'h123456);
        line_px(24'h234567);
        line_px(24'h345678);
        line_px(24'h456789);
        for (int i = 0; i < 4; i++) line_px(UF_RGB);
        idle(4);
        chk("lineC_pops", 32'(pops - pops0), 32'd1);
        chk("lineC_underflow_flag", 32'(underflow_flag), 32'd1);
`ifdef VIDEO_FIFO_UNDERFLOW_CNT_EN
        chk("lineC_underflow_cnt", 32'(underflow_cnt), 32'd1);
`endif

        // Reset mid-line, then the next line restarts at slot 0.
        fifo_q.push_back(mkword(pd[0], pd[1], pd[2], pd[3]));
        fifo_q.push_back(mkword(pd[4], pd[5], pd[6], pd[7]));
        pops0 = pops;
        line_px(pd[0]);
        line_px(pd[1]);
        line_px(pd[2]);
        video_de_in = 1'b1;
        #3;
        video_rst_n = 1'b0;
        exp_pix_q.delete();
        #1;
        chk("midrst_data", 32'(video_data_out), 32'd0);
        chk("midrst_de_out", 32'(video_de_out), 32'd0);
        chk("midrst_hs_out", 32'(video_hs_out), 32'd0);
        chk("midrst_underflow_flag", 32'(underflow_flag), 32'd0);
        chk("midrst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge video_clk);
        #1;
        idle(2);
        video_rst_n = 1'b1;
        idle(2);
        for (int i = 4; i < 8; i++) line_px(pd[i]);
        idle(4);
        chk("lineD_pops", 32'(pops - pops0), 32'd2);
        chk("final_scoreboard_drained", 32'(exp_pix_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
